// File: rtl/dmem_host_pkg.sv
// Shared types and widths for the data-memory host port.
// Width defaults apply when params.svh has not already defined them.
`ifndef WORDSZ
`define WORDSZ 16
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 5
`endif

package dmem_host_pkg;
  localparam int DW  = `WORDSZ;
  localparam int DAW = `RFSZLOG2;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP
  } state_t;
endpackage

// File: rtl/dmem_host_ofifo.sv
// Two-entry output FIFO holding dump words until the host takes them.
module dmem_host_ofifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [W-1:0] m0, m1;
  logic         wp, rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0    <= '0;
      m1    <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        if (wp) m1 <= push_data;
        else    m0 <= push_data;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_valid = count != 2'd0;
  assign out_data  = rp ? m1 : m0;
endmodule

// File: rtl/dmem_host_port.sv
// Host burst LOAD/DUMP engine for the data memory IO port.
// Define DMEM_HOST_CSUM_EN to enable the running XOR checksum.
module dmem_host_port
  import dmem_host_pkg::*;
#(
  parameter int WORDSZ = DW,
  parameter int AW     = DAW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [AW-1:0]     cmd_base,
  input  logic [AW-1:0]     cmd_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORDSZ-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORDSZ-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic [WORDSZ-1:0] csum,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_waddr,
  output logic [WORDSZ-1:0] mem_wdata,
  output logic              mem_ren,
  output logic [AW-1:0]     mem_raddr,
  input  logic [WORDSZ-1:0] mem_rdata
);
  localparam int CW = AW + 1;

  state_t        state, state_nx;
  logic [AW-1:0] base_q, cnt_q;
  logic [CW-1:0] widx, iss, inf_idx;
  logic          infl;
  logic [1:0]    fcount;
  logic [2:0]    occ;
  logic          cmd_fire, wlast, pop, dlast;
  logic          push, left;
  logic [WORDSZ:0] fifo_out;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wlast    = mem_wen && (widx == {1'b0, cnt_q});
  assign pop      = out_valid && out_ready;
  assign dlast    = pop && out_last;
  assign push     = infl && !busy;
  assign left     = iss <= {1'b0, cnt_q};
  assign occ      = {1'b0, fcount} + {2'b00, infl};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cmd_fire)
              state_nx = (cmd_op == OP_DUMP) ? DUMP : LOAD;
      LOAD: if (wlast) state_nx = IDLE;
      DUMP: if (dlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A slot freed by this cycle's pop can be refilled by this cycle's issue.
  always_comb begin
    cmd_ready = state == IDLE;
    in_ready  = (state == LOAD) && !busy;
    mem_wen   = in_ready && in_valid;
    mem_waddr = base_q + widx[AW-1:0];
    mem_wdata = mem_wen ? in_data : '0;
    mem_ren   = (state == DUMP) && !busy && left &&
                (occ < 3'd2 || (occ == 3'd2 && pop));
    mem_raddr = base_q + iss[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      cnt_q   <= '0;
      widx    <= '0;
      iss     <= '0;
      inf_idx <= '0;
      infl    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= wlast || dlast;
      infl <= mem_ren;
      if (cmd_fire) begin
        base_q <= cmd_base;
        cnt_q  <= cmd_cnt;
        widx   <= '0;
        iss    <= '0;
      end else begin
        if (mem_wen) widx <= widx + CW'(1);
        // A read landing while busy returns junk; rewind and reissue it.
        if (mem_ren) begin
          iss     <= iss + CW'(1);
          inf_idx <= iss;
        end else if (infl && busy) begin
          iss <= inf_idx;
        end
      end
    end
  end

  dmem_host_ofifo #(.W(WORDSZ + 1)) u_ofifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({inf_idx == {1'b0, cnt_q}, mem_rdata}),
    .pop       (pop),
    .count     (fcount),
    .out_valid (out_valid),
    .out_data  (fifo_out)
  );

  assign out_data = fifo_out[WORDSZ-1:0];
  assign out_last = out_valid && fifo_out[WORDSZ];

`ifdef DMEM_HOST_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           csum <= '0;
    else if (cmd_fire) csum <= '0;
    else if (mem_wen)  csum <= csum ^ in_data;
    else if (pop)      csum <= csum ^ out_data;
  end
`else
  assign csum = '0;
`endif
endmodule

// File: tb/tb_dmem_host_port.sv
// Randomized bench for dmem_host_port with a memory and burst reference model.
`timescale 1ns/1ps
module tb_dmem_host_port;
  import dmem_host_pkg::*;
  localparam int W = DW;
  localparam int A = DAW;
  localparam int D = 1 << A;

  logic clk = 1'b0;
  logic rst, busy;
  logic cmd_valid, cmd_ready, cmd_op;
  logic [A-1:0] cmd_base, cmd_cnt;
  logic in_valid, in_ready;
  logic [W-1:0] in_data;
  logic out_valid, out_ready, out_last, done;
  logic [W-1:0] out_data, csum;
  logic mem_wen, mem_ren;
  logic [A-1:0] mem_waddr, mem_raddr;
  logic [W-1:0] mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mem [D];
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] rdq;

  logic [A-1:0] wa_q [$];
  logic [W-1:0] wd_q [$];
  logic [W-1:0] od_q [$];
  logic         ol_q [$];
  logic [W-1:0] words [$];
  int ndone, first_ev, last_ev, first_ov, done_at;
  int io_viol, stable_viol, timeout;

  always #5 clk = ~clk;

  dmem_host_port dut (
    .clk(clk), .rst(rst), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_cnt(cmd_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .done(done), .csum(csum),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  // data_mem stand-in: address 0 stays 0, read data lags one cycle.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= (mem_waddr == '0) ? '0 : mem_wdata;
    if (mem_ren) rdq <= mem[mem_raddr];
  end
  assign mem_rdata = busy ? '0 : rdq;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit op, input int b, input int c);
    cmd_op = op;
    cmd_base = A'(b);
    cmd_cnt = A'(c);
    cmd_valid = 1'b1;
    timeout = 0;
    @(negedge clk);
    if (!cmd_ready) timeout = 1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input int b, input int c,
                         input int gap, input int bsy);
    int i = 0;
    words.delete(); wa_q.delete(); wd_q.delete();
    for (int n = 0; n <= c; n++) words.push_back(W'($urandom));
    ndone = 0; first_ev = -1; last_ev = -1; done_at = -1;
    send_cmd(1'b0, b, c);
    for (int k = 1; k <= 600; k++) begin
      busy = ($urandom_range(99) < bsy);
      in_valid = (i <= c) && ($urandom_range(99) >= gap);
      in_data = (i <= c) ? words[i] : '0;
      @(negedge clk);
      if (mem_wen) begin
        wa_q.push_back(mem_waddr);
        wd_q.push_back(mem_wdata);
        if (first_ev < 0) first_ev = k;
        last_ev = k;
      end
      if (in_valid && in_ready) i++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      step();
      if (done_at >= 0 && k >= done_at + 2) break;
    end
    in_valid = 1'b0; busy = 1'b0;
    if (done_at < 0) timeout = 1;
    for (int n = 0; n <= c; n++)
      ref_mem[(b + n) % D] = (((b + n) % D) == 0) ? '0 : words[n];
  endtask

  task automatic do_dump(input int b, input int c,
                         input int rmode, input int bmode);
    bit hold = 0;
    logic [W-1:0] pd = '0;
    logic pl = 1'b0;
    od_q.delete(); ol_q.delete();
    ndone = 0; first_ev = -1; last_ev = -1; first_ov = -1;
    done_at = -1; io_viol = 0; stable_viol = 0;
    send_cmd(1'b1, b, c);
    for (int k = 1; k <= 600; k++) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (k % 3) == 1;
        default: out_ready = 1'($urandom_range(1));
      endcase
      case (bmode)
        0: busy = 1'b0;
        1: busy = (k >= 2 && k <= 4);
        default: busy = ($urandom_range(99) < 20);
      endcase
      @(negedge clk);
      if (mem_ren && first_ev < 0) first_ev = k;
      if ((mem_ren && busy) || mem_wen) io_viol++;
      if (out_valid && first_ov < 0) first_ov = k;
      if (hold && (!out_valid || out_data !== pd || out_last !== pl))
        stable_viol++;
      hold = out_valid && !out_ready;
      pd = out_data; pl = out_last;
      if (out_valid && out_ready) begin
        od_q.push_back(out_data);
        ol_q.push_back(out_last);
        last_ev = k;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      step();
      if (done_at >= 0 && k >= done_at + 2) break;
    end
    out_ready = 1'b0; busy = 1'b0;
    if (done_at < 0) timeout = 1;
  endtask

  task automatic test_load(input string nm, input int b, input int c,
                           input int gap, input int bsy, input bit tim);
    logic [W-1:0] x = '0;
    do_load(b, c, gap, bsy);
    tests++;
    if (timeout !== 0) begin
      fails++; $display("FAIL %s timeout: got %0d want 0", nm, timeout);
    end
    tests++;
    if (wa_q.size() !== c + 1) begin
      fails++;
      $display("FAIL %s nwrites: got %0d want %0d", nm, wa_q.size(), c + 1);
    end
    for (int i = 0; i <= c && i < wa_q.size(); i++) begin
      tests++;
      if (wa_q[i] !== A'((b + i) % D) || wd_q[i] !== words[i]) begin
        fails++;
        $display("FAIL %s write%0d: got a=%0d d=%h want a=%0d d=%h",
                 nm, i, wa_q[i], wd_q[i], (b + i) % D, words[i]);
      end
      x ^= words[i];
    end
    tests++;
    if (ndone !== 1 || done_at !== last_ev + 1) begin
      fails++;
      $display("FAIL %s done: got n=%0d at %0d want n=1 at %0d",
               nm, ndone, done_at, last_ev + 1);
    end
    if (tim) begin
      tests++;
      if (first_ev !== 1 || last_ev !== c + 1) begin
        fails++;
        $display("FAIL %s timing: got %0d..%0d want 1..%0d",
                 nm, first_ev, last_ev, c + 1);
      end
    end
`ifndef DMEM_HOST_CSUM_EN
    x = '0;
`endif
    tests++;
    if (csum !== x) begin
      fails++; $display("FAIL %s csum: got %h want %h", nm, csum, x);
    end
  endtask

  task automatic test_dump(input string nm, input int b, input int c,
                           input int rmode, input int bmode, input bit tim);
    logic [W-1:0] x = '0;
    logic [W-1:0] e;
    do_dump(b, c, rmode, bmode);
    tests++;
    if (timeout !== 0 || io_viol !== 0 || stable_viol !== 0) begin
      fails++;
      $display("FAIL %s proto: got to=%0d io=%0d unstable=%0d want 0 0 0",
               nm, timeout, io_viol, stable_viol);
    end
    tests++;
    if (od_q.size() !== c + 1) begin
      fails++;
      $display("FAIL %s nwords: got %0d want %0d", nm, od_q.size(), c + 1);
    end
    for (int i = 0; i <= c && i < od_q.size(); i++) begin
      e = ref_mem[(b + i) % D];
      tests++;
      if (od_q[i] !== e || ol_q[i] !== (i == c)) begin
        fails++;
        $display("FAIL %s word%0d: got d=%h l=%b want d=%h l=%b",
                 nm, i, od_q[i], ol_q[i], e, i == c);
      end
      x ^= e;
    end
    tests++;
    if (ndone !== 1 || done_at !== last_ev + 1) begin
      fails++;
      $display("FAIL %s done: got n=%0d at %0d want n=1 at %0d",
               nm, ndone, done_at, last_ev + 1);
    end
    if (tim) begin
      tests++;
      if (first_ev !== 1 || first_ov !== 3 || last_ev !== c + 3) begin
        fails++;
        $display("FAIL %s timing: got ren=%0d ov=%0d end=%0d want 1 3 %0d",
                 nm, first_ev, first_ov, last_ev, c + 3);
      end
    end
`ifndef DMEM_HOST_CSUM_EN
    x = '0;
`endif
    tests++;
    if (csum !== x) begin
      fails++; $display("FAIL %s csum: got %h want %h", nm, csum, x);
    end
  endtask

  task automatic test_reset();
    logic [6:0] o;
    rst = 1'b1;
    step(); step();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      o = {cmd_ready, in_ready, out_valid, out_last, done, mem_wen, mem_ren};
      tests++;
      if (o !== 7'b1000000) begin
        fails++; $display("FAIL reset%0d flags: got %b want 1000000", r, o);
      end
      tests++;
      if ({out_data, csum, mem_wdata, mem_waddr, mem_raddr} !== '0) begin
        fails++;
        $display("FAIL reset%0d data: got od=%h cs=%h wd=%h wa=%0d ra=%0d want 0",
                 r, out_data, csum, mem_wdata, mem_waddr, mem_raddr);
      end
      step();
      rst = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    test_load("load_basic", 4, 3, 0, 0, 1'b1);
    test_dump("dump_basic", 4, 3, 0, 0, 1'b1);
  endtask

  task automatic test_wrap();
    test_load("load_wrap", D - 2, 3, 0, 0, 1'b1);
    test_dump("dump_wrap", D - 2, 3, 0, 0, 1'b1);
  endtask

  task automatic test_busy();
    test_dump("dump_busy", D - 2, 3, 0, 1, 1'b0);
    test_load("load_busy", 11, 9, 20, 30, 1'b0);
  endtask

  task automatic test_stall();
    test_dump("dump_stall", 10, 7, 1, 0, 1'b0);
    test_dump("dump_rand", 3, 12, 2, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(1) == 0)
        test_load("rnd_load", $urandom_range(D - 1),
                  $urandom_range(D - 1), 30, 15, 1'b0);
      else
        test_dump("rnd_dump", $urandom_range(D - 1),
                  $urandom_range(D - 1), 2, 2, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    logic [6:0] o;
    send_cmd(1'b1, 0, 20);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    o = {cmd_ready, in_ready, out_valid, out_last, done, mem_wen, mem_ren};
    tests++;
    if (o !== 7'b1000000 ||
        {out_data, csum, mem_wdata, mem_waddr, mem_raddr} !== '0) begin
      fails++;
      $display("FAIL rst_mid outputs: got %b od=%h cs=%h want 1000000 0 0",
               o, out_data, csum);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) nd++;
      step();
    end
    tests++;
    if (nd !== 0) begin
      fails++; $display("FAIL rst_mid done: got %0d want 0", nd);
    end
    test_load("load_after_rst", 9, 5, 10, 0, 1'b0);
    test_dump("dump_after_rst", 9, 5, 0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_cnt = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_load("fill", 0, D - 1, 10, 10, 1'b0);
    test_back_to_back();
    test_wrap();
    test_busy();
    test_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
